// File: rtl/spi_axis_pack.sv
// spi_axis_pack: services the SB_SPI system bus on interrupt, packs received
// bytes little-endian into DATA_W-bit words and streams them out through a
// first-word-fall-through FIFO with packet-boundary tlast.
// Optional feature macro: SPI_AXIS_PACK_TIMEOUT_EN (bus ack timeout watchdog).
module spi_axis_pack #(
  parameter int         DATA_W         = 32,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         PKT_WORDS      = 16,
  parameter logic [7:0] RX_ADDR_P      = 8'h05,
  parameter logic [7:0] IRQ_ADDR_P     = 8'h06,
  parameter int         IRQ_RRDY_BIT_P = 3,
  parameter logic [7:0] IRQ_CLR_MASK_P = 8'h08
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          spi_irq_i,
  output logic                          sb_stb_o,
  output logic                          sb_rw_o,
  output logic [7:0]                    sb_adr_o,
  output logic [7:0]                    sb_dat_o,
  input  logic [7:0]                    sb_dat_i,
  input  logic                          sb_ack_i,
  output logic [DATA_W-1:0]             tdata_o,
  output logic [DATA_W/8-1:0]           tkeep_o,
  output logic [DATA_W/8-1:0]           tstrb_o,
  output logic                          tlast_o,
  output logic                          tvalid_o,
  input  logic                          tready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o
`ifdef SPI_AXIS_PACK_TIMEOUT_EN
  ,
  output logic                          ack_timeout_o
`endif
);

  localparam int BYTES_P  = DATA_W / 8;
  localparam int IDX_W    = (BYTES_P > 1) ? $clog2(BYTES_P) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int WC_W     = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int PKT_LAST = (PKT_WORDS > 0) ? PKT_WORDS - 1 : 0;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_P - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(PKT_LAST);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic             PKT_EN   = (PKT_WORDS != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_IRQ  = 2'd1,
    RD_RX   = 2'd2,
    CLR_IRQ = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               stb_q, stb_d;
  logic               rw_q, rw_d;
  logic [7:0]         adr_q, adr_d;
  logic [7:0]         dat_q, dat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  asm_q, asm_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W:0]    mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  asm_ins;
  logic               push_last;
  logic [DATA_W:0]    head;
  logic               bus_wait;

  assign bus_wait = stb_q && !sb_ack_i;

`ifdef SPI_AXIS_PACK_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic        tmo_hit;

  assign tmo_hit = bus_wait && (tmo_q == 16'hFFFF);

  // Watchdog: count cycles the strobe is left unanswered, latch a sticky flag on expiry
  always_comb begin
    tmo_d      = bus_wait ? tmo_q + 16'd1 : 16'd0;
    tmo_flag_d = tmo_flag_q | tmo_hit;
    if (tmo_hit) begin
      tmo_d = 16'd0;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q      <= 16'd0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign ack_timeout_o = tmo_flag_q;
`endif

  // Bus sequencer and byte packer: each state launches its transaction while stb is low,
  // then waits for ack; ack drops stb so there is always an idle bus cycle in between
  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q;
    rw_d      = rw_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    wcnt_d    = wcnt_q;
    push      = 1'b0;
    asm_ins   = asm_q;
    asm_ins[8*idx_q +: 8] = sb_dat_i;
    push_last = PKT_EN && (wcnt_q == WC_LAST);

    unique case (state_q)
      IDLE: begin
        if (spi_irq_i && (count_q < CNT_FULL)) begin
          state_d = RD_IRQ;
          stb_d   = 1'b1;
          rw_d    = 1'b1;
          adr_d   = IRQ_ADDR_P;
          dat_d   = 8'h00;
        end
      end
      RD_IRQ: begin
        if (stb_q && sb_ack_i) begin
          stb_d   = 1'b0;
          state_d = sb_dat_i[IRQ_RRDY_BIT_P] ? RD_RX : CLR_IRQ;
        end
      end
      RD_RX: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          rw_d  = 1'b1;
          adr_d = RX_ADDR_P;
          dat_d = 8'h00;
        end else if (sb_ack_i) begin
          stb_d   = 1'b0;
          state_d = CLR_IRQ;
          if (idx_q == IDX_LAST) begin
            push   = 1'b1;
            idx_d  = '0;
            asm_d  = '0;
            wcnt_d = (wcnt_q == WC_LAST) ? '0 : wcnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            asm_d = asm_ins;
          end
        end
      end
      CLR_IRQ: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          rw_d  = 1'b0;
          adr_d = IRQ_ADDR_P;
          dat_d = IRQ_CLR_MASK_P;
        end else if (sb_ack_i) begin
          stb_d   = 1'b0;
          rw_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_AXIS_PACK_TIMEOUT_EN
    if (tmo_hit) begin
      stb_d   = 1'b0;
      rw_d    = 1'b1;
      state_d = IDLE;
      idx_d   = '0;
      asm_d   = '0;
    end
`endif
  end

  // FIFO pointer and occupancy bookkeeping; simultaneous push and pop keep the count
  always_comb begin
    pop      = tvalid_o && tready_i;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control and datapath registers, all cleared by reset (partial word discarded)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      stb_q    <= 1'b0;
      rw_q     <= 1'b1;
      adr_q    <= 8'h00;
      dat_q    <= 8'h00;
      idx_q    <= '0;
      asm_q    <= '0;
      wcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      rw_q     <= rw_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      wcnt_q   <= wcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage: {tlast, word} written at the push edge; contents need no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_last, asm_ins};
    end
  end

  // The space check in IDLE must make a push into a full FIFO impossible
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      push_on_full_a: assert (!(push && (count_q == CNT_FULL)));
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign tvalid_o     = (count_q != '0);
  assign tdata_o      = tvalid_o ? head[DATA_W-1:0] : '0;
  assign tlast_o      = tvalid_o && head[DATA_W];
  assign tkeep_o      = '1;
  assign tstrb_o      = '1;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != IDLE);
  assign sb_stb_o     = stb_q;
  assign sb_rw_o      = rw_q;
  assign sb_adr_o     = adr_q;
  assign sb_dat_o     = dat_q;

endmodule

// File: tb/tb_spi_axis_pack.sv
// Directed self-checking bench for spi_axis_pack (DATA_W=32, FIFO_DEPTH=4, PKT_WORDS=2).
// A behavioural SB_SPI model answers bus cycles; a stream monitor records popped words.
module tb_spi_axis_pack;

  logic        clk_i;
  logic        rst_i;
  logic        spi_irq_i;
  logic        sb_stb_o;
  logic        sb_rw_o;
  logic [7:0]  sb_adr_o;
  logic [7:0]  sb_dat_o;
  logic [7:0]  sb_dat_i;
  logic        sb_ack_i;
  logic [31:0] tdata_o;
  logic [3:0]  tkeep_o;
  logic [3:0]  tstrb_o;
  logic        tlast_o;
  logic        tvalid_o;
  logic        tready_i;
  logic [2:0]  fifo_count_o;
  logic        busy_o;
`ifdef SPI_AXIS_PACK_TIMEOUT_EN
  logic        ack_timeout_o;
`endif

  spi_axis_pack #(
    .DATA_W(32),
    .FIFO_DEPTH(4),
    .PKT_WORDS(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .spi_irq_i(spi_irq_i),
    .sb_stb_o(sb_stb_o),
    .sb_rw_o(sb_rw_o),
    .sb_adr_o(sb_adr_o),
    .sb_dat_o(sb_dat_o),
    .sb_dat_i(sb_dat_i),
    .sb_ack_i(sb_ack_i),
    .tdata_o(tdata_o),
    .tkeep_o(tkeep_o),
    .tstrb_o(tstrb_o),
    .tlast_o(tlast_o),
    .tvalid_o(tvalid_o),
    .tready_i(tready_i),
    .fifo_count_o(fifo_count_o),
    .busy_o(busy_o)
`ifdef SPI_AXIS_PACK_TIMEOUT_EN
    ,
    .ack_timeout_o(ack_timeout_o)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Stimulus side (written by the main sequence only)
  int         irq_req = 0;
  int         rx_wr = 0;
  logic [7:0] rx_mem [128];
  logic [7:0] irq_reg = 8'h08;
  logic       hold_rx = 1'b0;
  logic       hold_all = 1'b0;

  // Bus model side (written by the bus model only)
  int   irq_done = 0;
  int   rx_rd = 0;
  int   irq_rd = 0;
  int   clr_cnt = 0;
  int   bad_bus = 0;
  int   gap_err = 0;
  int   stb_rises = 0;
  logic stb_prev = 1'b0;
  logic was_rx = 1'b0;
  logic tv_log [128];

  // Stream monitor side
  int          pop_n = 0;
  logic [31:0] pop_data [64];
  logic        pop_last [64];

  assign spi_irq_i = (irq_req != irq_done);

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // SB_SPI model: acks one cycle after strobe, decodes register accesses
  initial begin
    sb_ack_i = 1'b0;
    sb_dat_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (sb_stb_o && !stb_prev) stb_rises++;
      stb_prev = sb_stb_o;
      if (rst_i) begin
        sb_ack_i = 1'b0;
        was_rx   = 1'b0;
      end else if (sb_ack_i) begin
        sb_ack_i = 1'b0;
        if (sb_stb_o) gap_err++;
        if (was_rx) tv_log[(rx_rd - 1) & 127] = tvalid_o;
        was_rx = 1'b0;
      end else if (sb_stb_o && !hold_all && !(hold_rx && sb_adr_o == 8'h05)) begin
        sb_ack_i = 1'b1;
        if (!sb_rw_o) begin
          clr_cnt++;
          if (sb_adr_o != 8'h06 || sb_dat_o != 8'h08) bad_bus++;
          if (irq_done != irq_req) irq_done++;
          sb_dat_i = 8'h00;
        end else if (sb_adr_o == 8'h06) begin
          irq_rd++;
          sb_dat_i = irq_reg;
        end else if (sb_adr_o == 8'h05) begin
          sb_dat_i = rx_mem[rx_rd & 127];
          rx_rd++;
          was_rx = 1'b1;
        end else begin
          bad_bus++;
          sb_dat_i = 8'h00;
        end
      end
    end
  end

  // Stream monitor: a handshake seen at the negedge completes at the next posedge
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && tvalid_o && tready_i) begin
      pop_data[pop_n & 63] = tdata_o;
      pop_last[pop_n & 63] = tlast_o;
      pop_n++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue one received byte and raise one interrupt event for it
  task automatic applyStimulus(input logic [7:0] b);
    rx_mem[rx_wr & 127] = b;
    rx_wr++;
    irq_req++;
  endtask

  task automatic doReset();
    rst_i   = 1'b1;
    irq_req = irq_done;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic waitServiced(input string tag, input int bound);
    int n = 0;
    while (!(irq_req == irq_done && !busy_o) && n < bound) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput({tag, "_done"}, 64'(n < bound), 64'd1);
  endtask

  task automatic waitEmpty(input string tag, input int bound);
    int n = 0;
    while (fifo_count_o != 3'd0 && n < bound) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput({tag, "_empty"}, 64'(n < bound), 64'd1);
  endtask

  initial begin
    logic [31:0] exp_w3 [4];
    logic [31:0] exp_w4 [5];
    logic        exp_l [5];
    int rxb;
    int irb;
    int clb;
    int pb;
    int sb;
    int n;

    exp_w3[0] = 32'h04030201; exp_w3[1] = 32'h08070605;
    exp_w3[2] = 32'h0C0B0A09; exp_w3[3] = 32'h100F0E0D;
    exp_w4[0] = 32'h23222120; exp_w4[1] = 32'h27262524;
    exp_w4[2] = 32'h2B2A2928; exp_w4[3] = 32'h2F2E2D2C;
    exp_w4[4] = 32'h33323130;
    exp_l[0] = 1'b0; exp_l[1] = 1'b1; exp_l[2] = 1'b0; exp_l[3] = 1'b1; exp_l[4] = 1'b0;

    rst_i    = 1'b1;
    tready_i = 1'b0;
    #1;
    doReset();

    // Reset values
    checkOutput("rst_stb",   64'(sb_stb_o), 64'd0);
    checkOutput("rst_rw",    64'(sb_rw_o), 64'd1);
    checkOutput("rst_adr",   64'(sb_adr_o), 64'h00);
    checkOutput("rst_dat",   64'(sb_dat_o), 64'h00);
    checkOutput("rst_tvalid", 64'(tvalid_o), 64'd0);
    checkOutput("rst_tlast", 64'(tlast_o), 64'd0);
    checkOutput("rst_tdata", 64'(tdata_o), 64'h0);
    checkOutput("rst_count", 64'(fifo_count_o), 64'd0);
    checkOutput("rst_busy",  64'(busy_o), 64'd0);
    checkOutput("rst_keep",  64'(tkeep_o), 64'hF);

    // Four bytes pack into one little-endian word
    $display("[TB] single word packing");
    rxb = rx_rd; irb = irq_rd; clb = clr_cnt;
    applyStimulus(8'h11); applyStimulus(8'h22);
    applyStimulus(8'h33); applyStimulus(8'h44);
    waitServiced("w1", 200);
    checkOutput("w1_tdata",  64'(tdata_o), 64'h44332211);
    checkOutput("w1_tvalid", 64'(tvalid_o), 64'd1);
    checkOutput("w1_tlast",  64'(tlast_o), 64'd0);
    checkOutput("w1_count",  64'(fifo_count_o), 64'd1);
    checkOutput("w1_rxrd",   64'(rx_rd - rxb), 64'd4);
    checkOutput("w1_irqrd",  64'(irq_rd - irb), 64'd4);
    checkOutput("w1_clr",    64'(clr_cnt - clb), 64'd4);
    checkOutput("w1_tv3",    64'(tv_log[(rxb + 2) & 127]), 64'd0);
    checkOutput("w1_tv4",    64'(tv_log[(rxb + 3) & 127]), 64'd1);
    tready_i = 1'b1;
    waitEmpty("w1", 20);
    tready_i = 1'b0;

    // IRQ with RRDY clear: clear only, no RX read, no push
    $display("[TB] spurious interrupt");
    doReset();
    irq_reg = 8'h00;
    rxb = rx_rd; irb = irq_rd; clb = clr_cnt;
    irq_req++;
    waitServiced("nr", 100);
    checkOutput("nr_irqrd", 64'(irq_rd - irb), 64'd1);
    checkOutput("nr_rxrd",  64'(rx_rd - rxb), 64'd0);
    checkOutput("nr_clr",   64'(clr_cnt - clb), 64'd1);
    checkOutput("nr_count", 64'(fifo_count_o), 64'd0);
    checkOutput("nr_busy",  64'(busy_o), 64'd0);
    irq_reg = 8'h08;

    // Packet framing, sink always ready
    $display("[TB] packet tlast");
    doReset();
    tready_i = 1'b1;
    pb = pop_n;
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
    waitServiced("pk", 1000);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("pk_words", 64'(pop_n - pb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("pk_data%0d", i), 64'(pop_data[(pb + i) & 63]), 64'(exp_w3[i]));
      checkOutput($sformatf("pk_last%0d", i), 64'(pop_last[(pb + i) & 63]), 64'(exp_l[i]));
    end

    // Back-pressure: FIFO fills, servicing stalls, then drains in order
    $display("[TB] fifo full stall");
    doReset();
    tready_i = 1'b0;
    pb = pop_n;
    for (int i = 0; i < 20; i++) applyStimulus(8'(8'h20 + i));
    n = 0;
    while (!(fifo_count_o == 3'd4 && !busy_o) && n < 1000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput("ff_reach_full", 64'(n < 1000), 64'd1);
    sb = stb_rises;
    repeat (40) @(posedge clk_i);
    #1;
    checkOutput("ff_no_stb", 64'(stb_rises - sb), 64'd0);
    checkOutput("ff_count",  64'(fifo_count_o), 64'd4);
    checkOutput("ff_irq",    64'(spi_irq_i), 64'd1);
    checkOutput("ff_head",   64'(tdata_o), 64'h23222120);
    tready_i = 1'b1;
    waitServiced("ff", 1000);
    waitEmpty("ff", 50);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("ff_words", 64'(pop_n - pb), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("ff_data%0d", i), 64'(pop_data[(pb + i) & 63]), 64'(exp_w4[i]));
      checkOutput($sformatf("ff_last%0d", i), 64'(pop_last[(pb + i) & 63]), 64'(exp_l[i]));
    end
    tready_i = 1'b0;

    // Reset in the middle of an RX read discards the partial word
    $display("[TB] reset mid transaction");
    doReset();
    applyStimulus(8'hAA);
    waitServiced("mr_pre", 100);
    hold_rx = 1'b1;
    irq_req++;
    n = 0;
    while (!(sb_stb_o && sb_adr_o == 8'h05) && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput("mr_in_rx", 64'(n < 100), 64'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("mr_stb",   64'(sb_stb_o), 64'd0);
    checkOutput("mr_count", 64'(fifo_count_o), 64'd0);
    checkOutput("mr_busy",  64'(busy_o), 64'd0);
    irq_req = irq_done;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    hold_rx = 1'b0;
    applyStimulus(8'h55); applyStimulus(8'h66);
    applyStimulus(8'h77); applyStimulus(8'h88);
    waitServiced("mr", 200);
    checkOutput("mr_tdata", 64'(tdata_o), 64'h88776655);
    checkOutput("mr_cnt1",  64'(fifo_count_o), 64'd1);

`ifdef SPI_AXIS_PACK_TIMEOUT_EN
    // Ack never returned: watchdog drops the strobe and flags the timeout
    $display("[TB] ack timeout");
    doReset();
    hold_all = 1'b1;
    irq_req++;
    n = 0;
    while (!sb_stb_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput("to_stb_up", 64'(sb_stb_o), 64'd1);
    sb = cyc;
    irq_req = irq_done;
    n = 0;
    while (sb_stb_o && n < 70000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput("to_len", 64'((cyc - sb) >= 65535 && (cyc - sb) <= 65537), 64'd1);
    checkOutput("to_flag", 64'(ack_timeout_o), 64'd1);
    checkOutput("to_busy", 64'(busy_o), 64'd0);
    hold_all = 1'b0;
    doReset();
    checkOutput("to_flag_rst", 64'(ack_timeout_o), 64'd0);
`endif

    checkOutput("bus_gap", 64'(gap_err), 64'd0);
    checkOutput("bus_bad", 64'(bad_bus), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_axis_pack.md
Name: spi_axis_pack

Overview:
- Parametrised successor of the single-byte SPI-to-stream bridge.
- Services the hardened SPI macro's system bus on interrupt and reads received bytes from it.
- Packs BYTES_P = DATA_W/8 bytes little-endian into one AXI-Stream word and buffers words in an output FIFO.
- Asserts tlast on the last word of each fixed-length packet; sits between the SB_SPI instance and the downstream pixel pipeline.

Parameters:
- DATA_W, 32, stream word width; multiple of 8, 8..64
- FIFO_DEPTH, 4, output FIFO depth in words; power of 2, >=2
- PKT_WORDS, 16, words per packet for tlast; 0 = tlast never asserted
- RX_ADDR_P, 8'h05, SPI RX data register address
- IRQ_ADDR_P, 8'h06, SPI IRQ status/clear register address
- IRQ_RRDY_BIT_P, 3, RX-ready bit index in the IRQ register
- IRQ_CLR_MASK_P, 8'h08, write-1-to-clear mask written to IRQ_ADDR_P

Ports:
- clk_i  in  1  core and system-bus clock
- rst_i  in  1  synchronous active-high reset
- spi_irq_i  in  1  macro interrupt request
- sb_stb_o  out  1  bus strobe
- sb_rw_o  out  1  1 = read, 0 = write
- sb_adr_o  out  8  register address
- sb_dat_o  out  8  write data
- sb_dat_i  in  8  read data, valid while sb_ack_i = 1
- sb_ack_i  in  1  transaction acknowledge
- tdata_o  out  DATA_W  stream payload
- tkeep_o  out  DATA_W/8  all ones
- tstrb_o  out  DATA_W/8  all ones
- tlast_o  out  1  last word of packet
- tvalid_o  out  1  FIFO not empty
- tready_i  in  1  sink ready
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  words held
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values: sb_stb_o=0, sb_rw_o=1, sb_adr_o=0, sb_dat_o=0, tvalid_o=0, tlast_o=0, tdata_o=0, fifo_count_o=0, busy_o=0.
- Reset also clears the byte index, word counter and FIFO pointers.
- Reset mid-transaction drops stb on the next edge and discards the partial word.
- Bus transaction:
  - Drive stb/adr/rw/dat together on one edge; hold them until sb_ack_i=1 is sampled.
  - Drop stb on the edge that samples ack.
  - At least one stb-low cycle between transactions.
  - Read data is captured on the ack cycle.
- FSM states: IDLE, RD_IRQ, RD_RX, CLR_IRQ.
  - IDLE -> RD_IRQ when spi_irq_i=1 and fifo_count_o < FIFO_DEPTH.
  - RD_IRQ: read IRQ_ADDR_P. On ack, go to RD_RX if sb_dat_i[IRQ_RRDY_BIT_P]=1, else CLR_IRQ.
  - RD_RX: read RX_ADDR_P; on ack, store the byte and go to CLR_IRQ.
  - CLR_IRQ: write IRQ_CLR_MASK_P to IRQ_ADDR_P; on ack, go to IDLE.
- Packing:
  - Byte index k (0..BYTES_P-1) writes sb_dat_i into bits [8k+7:8k] of the assembly register, then increments.
  - When k = BYTES_P-1: push the assembled word to the FIFO and wrap k to 0.
  - Pushed tlast = (PKT_WORDS != 0 && word_cnt == PKT_WORDS-1). word_cnt increments per push and wraps to 0 after PKT_WORDS-1.
- FIFO:
  - First-word-fall-through; tdata_o/tlast_o come from the head entry.
  - tvalid_o asserts the cycle after the push edge (1-cycle latency from the ack of the final byte).
  - Pop when tvalid_o && tready_i. tdata_o/tlast_o hold while tvalid_o && !tready_i.
  - Push and pop in the same cycle leave the count unchanged.
  - The IDLE space check plus at most one push in flight guarantee no overflow. A push on full never occurs; assert this in simulation.
- DATA_W=8 degenerates to one word per RX byte.

Optional Feature:
- SPI_AXIS_PACK_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs while sb_stb_o=1 without ack.
  - At 65535 it drops stb, returns the FSM to IDLE, clears the byte index (partial word discarded) and sets sticky output ack_timeout_o.
  - ack_timeout_o clears only on rst_i.
- Undefined: no counter and no ack_timeout_o port; the FSM waits for ack indefinitely.

Test Plan:
- DATA_W=32; 4 IRQ events with RRDY=1, RX bytes 11,22,33,44 -> one word tdata=0x44332211, tvalid 1 cycle after 4th read ack; 4 clear writes of 0x08 to 0x06.
- IRQ read returning 0x00 -> no RX read, one clear write, no push, returns to IDLE.
- PKT_WORDS=2, 16 bytes, tready=1 -> 4 words, tlast=0,1,0,1.
- FIFO_DEPTH=4, tready=0, 20 bytes -> count saturates at 4, spi_irq_i held high with no bus strobes; tready=1 drains words in order and servicing resumes.
- Reset asserted during RD_RX with stb high -> stb=0 next cycle, count=0; next 4 bytes form a full fresh word.
- With SPI_AXIS_PACK_TIMEOUT_EN, ack never returned -> stb drops after 65535 cycles, ack_timeout_o=1, FSM in IDLE.
